// File: rtl/pipe_ctrl_hazard_pkg.sv
// Shared definitions for the 5-stage control pipeline: ALU op classes, forward
// selects and the control bundle carried by every stage register.
package pipe_ctrl_hazard_pkg;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REGF = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

  localparam int unsigned LINK_REG_DEF = 31;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src;
    logic    branch;
    logic    mem_read;
    logic    mem_write;
    logic    reg_write;
    logic    mem_to_reg;
    logic    jal;
  } ctrl_t;

endpackage

// File: rtl/pipe_fwd_unit.sv
// EX-stage operand forwarding: a pending MEM write wins over a pending WB write;
// register 0 is never forwarded.
module pipe_fwd_unit
  import pipe_ctrl_hazard_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic            mem_reg_write_i,
  input  logic [RA_W-1:0] mem_write_reg_i,
  input  logic            wb_reg_write_i,
  input  logic [RA_W-1:0] wb_write_reg_i,
  input  logic [RA_W-1:0] ex_rs_i,
  input  logic [RA_W-1:0] ex_rt_i,
  output logic [1:0]      fwd_a_o,
  output logic [1:0]      fwd_b_o
);

  function automatic fwd_sel_e pick(input logic [RA_W-1:0] src);
    if (mem_reg_write_i && (mem_write_reg_i != '0) && (mem_write_reg_i == src))
      return FWD_MEM;
    else if (wb_reg_write_i && (wb_write_reg_i != '0) && (wb_write_reg_i == src))
      return FWD_WB;
    else
      return FWD_REGF;
  endfunction

  assign fwd_a_o = pick(ex_rs_i);
  assign fwd_b_o = pick(ex_rt_i);

endmodule

// File: rtl/pipe_ctrl_hazard.sv
// Control-path pipeline ID->EX->MEM->WB with load-use stall, branch/jump flush,
// forwarding selects and saturating stall/flush event counters.
module pipe_ctrl_hazard
  import pipe_ctrl_hazard_pkg::*;
#(
  parameter int RA_W     = 5,
  parameter int CNT_W    = 16,
  parameter int LINK_REG = LINK_REG_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IdRegDst,
  input  logic             IdJump,
  input  logic             IdBranch,
  input  logic             IdMemRead,
  input  logic             IdMemtoReg,
  input  logic             IdMemWrite,
  input  logic             IdALUSrc,
  input  logic             IdRegWrite,
  input  logic             IdJAL,
  input  logic [1:0]       IdALUOp,
  input  logic [RA_W-1:0]  IdRs,
  input  logic [RA_W-1:0]  IdRt,
  input  logic [RA_W-1:0]  IdRd,
  input  logic             ExBranchTaken,
  output logic [1:0]       ExALUOp,
  output logic             ExALUSrc,
  output logic             ExBranch,
  output logic [RA_W-1:0]  ExRs,
  output logic [RA_W-1:0]  ExRt,
  output logic [RA_W-1:0]  ExWriteReg,
  output logic             MemMemRead,
  output logic             MemMemWrite,
  output logic             MemRegWrite,
  output logic [RA_W-1:0]  MemWriteReg,
  output logic             WbRegWrite,
  output logic             WbMemtoReg,
  output logic             WbJAL,
  output logic [RA_W-1:0]  WbWriteReg,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam logic [RA_W-1:0] LINK_ADDR = RA_W'(LINK_REG);

  ctrl_t           id_ctrl, ex_d, ex_q, mem_q, wb_q;
  logic [RA_W-1:0] ex_rs_d, ex_rs_q, ex_rt_d, ex_rt_q, ex_wr_d, ex_wr_q;
  logic [RA_W-1:0] mem_wr_q, wb_wr_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;
  logic load_use, flush, stall, ifid_flush;

  assign id_ctrl = '{
    alu_op:     alu_op_e'(IdALUOp),
    alu_src:    IdALUSrc,
    branch:     IdBranch,
    mem_read:   IdMemRead,
    mem_write:  IdMemWrite,
    reg_write:  IdRegWrite,
    mem_to_reg: IdMemtoReg,
    jal:        IdJAL
  };

  // A taken branch squashes the ID instruction, so any hazard it raised is moot.
  assign flush      = ex_q.branch & ExBranchTaken;
  assign load_use   = ex_q.mem_read & (ex_rt_q != '0) & ((ex_rt_q == IdRs) | (ex_rt_q == IdRt));
  assign stall      = load_use & ~flush;
  assign ifid_flush = flush | (IdJump & ~stall);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    ex_d    = id_ctrl;
    ex_rs_d = IdRs;
    ex_rt_d = IdRt;
    ex_wr_d = IdJAL ? LINK_ADDR : (IdRegDst ? IdRd : IdRt);
    if (stall || flush) begin
      ex_d    = '0;
      ex_rs_d = '0;
      ex_rt_d = '0;
      ex_wr_d = '0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (ifid_flush && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so each stage samples the previous stage's old value.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_q        <= '0;
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
      ex_wr_q     <= '0;
      mem_q       <= '0;
      mem_wr_q    <= '0;
      wb_q        <= '0;
      wb_wr_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      ex_rs_q     <= ex_rs_d;
      ex_rt_q     <= ex_rt_d;
      ex_wr_q     <= ex_wr_d;
      mem_q       <= ex_q;
      mem_wr_q    <= ex_wr_q;
      wb_q        <= mem_q;
      wb_wr_q     <= mem_wr_q;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  pipe_fwd_unit #(.RA_W(RA_W)) u_fwd (
    .mem_reg_write_i (mem_q.reg_write),
    .mem_write_reg_i (mem_wr_q),
    .wb_reg_write_i  (wb_q.reg_write),
    .wb_write_reg_i  (wb_wr_q),
    .ex_rs_i         (ex_rs_q),
    .ex_rt_i         (ex_rt_q),
    .fwd_a_o         (ForwardA),
    .fwd_b_o         (ForwardB)
  );

  assign ExALUOp     = ex_q.alu_op;
  assign ExALUSrc    = ex_q.alu_src;
  assign ExBranch    = ex_q.branch;
  assign ExRs        = ex_rs_q;
  assign ExRt        = ex_rt_q;
  assign ExWriteReg  = ex_wr_q;
  assign MemMemRead  = mem_q.mem_read;
  assign MemMemWrite = mem_q.mem_write;
  assign MemRegWrite = mem_q.reg_write;
  assign MemWriteReg = mem_wr_q;
  assign WbRegWrite  = wb_q.reg_write;
  assign WbMemtoReg  = wb_q.mem_to_reg;
  assign WbJAL       = wb_q.jal;
  assign WbWriteReg  = wb_wr_q;
  assign PCWrite     = ~stall;
  assign IFIDWrite   = ~stall;
  assign IFIDFlush   = ifid_flush;
  assign StallCount  = stall_cnt_q;
  assign FlushCount  = flush_cnt_q;

  // Fields a later stage no longer needs; kept in the shared bundle for uniformity.
  logic unused_ctrl;
  assign unused_ctrl = ^{ex_q.mem_to_reg, mem_q.alu_op, mem_q.alu_src, mem_q.branch, mem_q.mem_to_reg,
                         mem_q.jal, wb_q.alu_op, wb_q.alu_src, wb_q.branch, wb_q.mem_read, wb_q.mem_write};

endmodule

// File: tb/tb_pipe_ctrl_hazard.sv
// Self-checking bench for pipe_ctrl_hazard: directed scenarios plus random traffic
// compared cycle-by-cycle with a queue-style model of the control pipeline.
module tb_pipe_ctrl_hazard;
  localparam int RA_W    = 5;
  localparam int CNT_W   = 8;
  localparam int LINK    = 31;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int VW      = 42 + 2 * CNT_W;

  logic CLK = 1'b0;
  logic RST;
  logic IdRegDst, IdJump, IdBranch, IdMemRead, IdMemtoReg, IdMemWrite, IdALUSrc, IdRegWrite, IdJAL;
  logic [1:0] IdALUOp;
  logic [RA_W-1:0] IdRs, IdRt, IdRd;
  logic ExBranchTaken;
  logic [1:0] ExALUOp, ForwardA, ForwardB;
  logic ExALUSrc, ExBranch, MemMemRead, MemMemWrite, MemRegWrite, WbRegWrite, WbMemtoReg, WbJAL;
  logic PCWrite, IFIDWrite, IFIDFlush;
  logic [RA_W-1:0] ExRs, ExRt, ExWriteReg, MemWriteReg, WbWriteReg;
  logic [CNT_W-1:0] StallCount, FlushCount;

  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  pipe_ctrl_hazard #(.RA_W(RA_W), .CNT_W(CNT_W), .LINK_REG(LINK)) dut (
    .CLK(CLK), .RST(RST),
    .IdRegDst(IdRegDst), .IdJump(IdJump), .IdBranch(IdBranch), .IdMemRead(IdMemRead),
    .IdMemtoReg(IdMemtoReg), .IdMemWrite(IdMemWrite), .IdALUSrc(IdALUSrc), .IdRegWrite(IdRegWrite),
    .IdJAL(IdJAL), .IdALUOp(IdALUOp), .IdRs(IdRs), .IdRt(IdRt), .IdRd(IdRd),
    .ExBranchTaken(ExBranchTaken),
    .ExALUOp(ExALUOp), .ExALUSrc(ExALUSrc), .ExBranch(ExBranch), .ExRs(ExRs), .ExRt(ExRt),
    .ExWriteReg(ExWriteReg), .MemMemRead(MemMemRead), .MemMemWrite(MemMemWrite),
    .MemRegWrite(MemRegWrite), .MemWriteReg(MemWriteReg), .WbRegWrite(WbRegWrite),
    .WbMemtoReg(WbMemtoReg), .WbJAL(WbJAL), .WbWriteReg(WbWriteReg),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
    .IFIDFlush(IFIDFlush), .StallCount(StallCount), .FlushCount(FlushCount)
  );

  logic [VW-1:0] dut_vec;
  assign dut_vec = {ExALUOp, ExALUSrc, ExBranch, ExRs, ExRt, ExWriteReg, MemMemRead, MemMemWrite,
                    MemRegWrite, MemWriteReg, WbRegWrite, WbMemtoReg, WbJAL, WbWriteReg,
                    ForwardA, ForwardB, PCWrite, IFIDWrite, IFIDFlush, StallCount, FlushCount};

  // ---------------- reference model ----------------
  typedef struct {
    bit reg_dst, jump, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, jal;
    bit [1:0] alu_op;
    bit [4:0] rs, rt, rd;
  } instr_t;

  typedef struct {
    bit [1:0] alu_op;
    bit alu_src, branch, mem_read, mem_write, reg_write, mem_to_reg, jal;
    bit [4:0] rs, rt, wr;
  } slot_t;

  slot_t  pipe_m [3];  // index 0 = EX, 1 = MEM, 2 = WB
  int     stall_m, flush_m;
  instr_t id_cur;
  bit     taken_cur, rst_cur;

  function automatic bit m_flush();
    return pipe_m[0].branch && taken_cur;
  endfunction

  function automatic bit m_stall();
    bit hit;
    hit = pipe_m[0].mem_read && pipe_m[0].rt != 0 && (pipe_m[0].rt == id_cur.rs || pipe_m[0].rt == id_cur.rt);
    return hit && !m_flush();
  endfunction

  function automatic bit m_iflush();
    return m_flush() || (id_cur.jump && !m_stall());
  endfunction

  function automatic bit [1:0] m_fwd(input bit [4:0] src);
    if (pipe_m[1].reg_write && pipe_m[1].wr != 0 && pipe_m[1].wr == src) return 2'b10;
    if (pipe_m[2].reg_write && pipe_m[2].wr != 0 && pipe_m[2].wr == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    slot_t e, m, w;
    logic [CNT_W-1:0] sc, fc;
    e = pipe_m[0]; m = pipe_m[1]; w = pipe_m[2];
    sc = CNT_W'(stall_m); fc = CNT_W'(flush_m);
    return {e.alu_op, e.alu_src, e.branch, e.rs, e.rt, e.wr, m.mem_read, m.mem_write,
            m.reg_write, m.wr, w.reg_write, w.mem_to_reg, w.jal, w.wr,
            m_fwd(e.rs), m_fwd(e.rt), !m_stall(), !m_stall(), m_iflush(), sc, fc};
  endfunction

  task automatic model_clock();
    slot_t nxt;
    bit st, fl, ifl;
    if (rst_cur) begin
      for (int i = 0; i < 3; i++) pipe_m[i] = '{default: 0};
      stall_m = 0; flush_m = 0;
      return;
    end
    st = m_stall(); fl = m_flush(); ifl = m_iflush();
    nxt = '{default: 0};
    if (!st && !fl) begin
      nxt.alu_op = id_cur.alu_op; nxt.alu_src = id_cur.alu_src; nxt.branch = id_cur.branch;
      nxt.mem_read = id_cur.mem_read; nxt.mem_write = id_cur.mem_write;
      nxt.reg_write = id_cur.reg_write; nxt.mem_to_reg = id_cur.mem_to_reg; nxt.jal = id_cur.jal;
      nxt.rs = id_cur.rs; nxt.rt = id_cur.rt;
      nxt.wr = id_cur.jal ? 5'(LINK) : (id_cur.reg_dst ? id_cur.rd : id_cur.rt);
    end
    pipe_m[2] = pipe_m[1]; pipe_m[1] = pipe_m[0]; pipe_m[0] = nxt;
    if (st && stall_m < CNT_MAX) stall_m++;
    if (ifl && flush_m < CNT_MAX) flush_m++;
  endtask

  // ---------------- instruction builders ----------------
  function automatic instr_t nop();
    instr_t r;
    r = '{default: 0};
    return r;
  endfunction

  function automatic instr_t rtype(input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd, input bit [1:0] op);
    instr_t r;
    r = nop(); r.reg_dst = 1; r.reg_write = 1; r.alu_op = op; r.rs = rs; r.rt = rt; r.rd = rd;
    return r;
  endfunction

  function automatic instr_t lw(input bit [4:0] rs, input bit [4:0] rt);
    instr_t r;
    r = nop(); r.mem_read = 1; r.mem_to_reg = 1; r.reg_write = 1; r.alu_src = 1; r.rs = rs; r.rt = rt;
    return r;
  endfunction

  function automatic instr_t sw(input bit [4:0] rs, input bit [4:0] rt);
    instr_t r;
    r = nop(); r.mem_write = 1; r.alu_src = 1; r.rs = rs; r.rt = rt;
    return r;
  endfunction

  function automatic instr_t beq(input bit [4:0] rs, input bit [4:0] rt);
    instr_t r;
    r = nop(); r.branch = 1; r.alu_op = 2'b01; r.rs = rs; r.rt = rt;
    return r;
  endfunction

  function automatic instr_t jmp(input bit link);
    instr_t r;
    r = nop(); r.jump = 1; r.jal = link; r.reg_write = link;
    return r;
  endfunction

  function automatic instr_t rand_instr();
    instr_t r;
    r.reg_dst = 1'($urandom); r.jump = ($urandom_range(0, 7) == 0); r.branch = ($urandom_range(0, 3) == 0);
    r.mem_read = 1'($urandom); r.mem_to_reg = 1'($urandom); r.mem_write = 1'($urandom);
    r.alu_src = 1'($urandom); r.reg_write = 1'($urandom); r.jal = ($urandom_range(0, 7) == 0);
    r.alu_op = 2'($urandom_range(0, 2));
    r.rs = 5'($urandom_range(0, 3)); r.rt = 5'($urandom_range(0, 3)); r.rd = 5'($urandom_range(0, 3));
    return r;
  endfunction

  // ---------------- drive / clock ----------------
  task automatic apply(input instr_t i, input bit taken, input bit rst);
    id_cur = i; taken_cur = taken; rst_cur = rst;
    RST = rst; ExBranchTaken = taken;
    IdRegDst = i.reg_dst; IdJump = i.jump; IdBranch = i.branch; IdMemRead = i.mem_read;
    IdMemtoReg = i.mem_to_reg; IdMemWrite = i.mem_write; IdALUSrc = i.alu_src;
    IdRegWrite = i.reg_write; IdJAL = i.jal; IdALUOp = i.alu_op;
    IdRs = i.rs; IdRt = i.rt; IdRd = i.rd;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_clock();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    apply(nop(), 0, 1);
    tick();
    apply(nop(), 0, 0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL reset_state: got %h want %h", dut_vec, exp_vec()); end
    total++; if (PCWrite !== 1'b1 || IFIDWrite !== 1'b1) begin bad++; $display("FAIL reset_enables: got %b%b want 11", PCWrite, IFIDWrite); end
    total++; if (IFIDFlush !== 1'b0 || ForwardA !== 2'b00 || ForwardB !== 2'b00) begin bad++; $display("FAIL reset_flush_fwd: got %b %b %b want 0 00 00", IFIDFlush, ForwardA, ForwardB); end
    total++; if (StallCount !== '0 || FlushCount !== '0) begin bad++; $display("FAIL reset_counts: got %0d %0d want 0 0", StallCount, FlushCount); end
  endtask

  task automatic test_rtype();
    do_reset();
    apply(rtype(1, 2, 8, 2'b10), 0, 0);
    tick();
    apply(nop(), 0, 0);
    tick(); tick();
    total++; if (WbRegWrite !== 1'b1 || WbWriteReg !== 5'd8 || WbMemtoReg !== 1'b0) begin bad++; $display("FAIL rtype_wb: got %b %0d %b want 1 8 0", WbRegWrite, WbWriteReg, WbMemtoReg); end
    total++; if (StallCount !== '0 || FlushCount !== '0) begin bad++; $display("FAIL rtype_counts: got %0d %0d want 0 0", StallCount, FlushCount); end
  endtask

  task automatic test_load_use();
    do_reset();
    apply(lw(1, 9), 0, 0);
    tick();
    apply(rtype(9, 3, 10, 2'b10), 0, 0);
    total++; if (PCWrite !== 1'b0 || IFIDWrite !== 1'b0) begin bad++; $display("FAIL lu_stall: got %b%b want 00", PCWrite, IFIDWrite); end
    tick();
    total++; if (ExRs !== 5'd0 || ExWriteReg !== 5'd0 || ExALUOp !== 2'b00 || StallCount !== 8'd1) begin bad++; $display("FAIL lu_bubble: got rs=%0d wr=%0d op=%0d sc=%0d want 0 0 0 1", ExRs, ExWriteReg, ExALUOp, StallCount); end
    total++; if (PCWrite !== 1'b1) begin bad++; $display("FAIL lu_release: got %b want 1", PCWrite); end
    tick();
    total++; if (ExRs !== 5'd9 || ForwardA !== 2'b01 || StallCount !== 8'd1) begin bad++; $display("FAIL lu_fwd_wb: got rs=%0d fa=%b sc=%0d want 9 01 1", ExRs, ForwardA, StallCount); end
    total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL lu_model: got %h want %h", dut_vec, exp_vec()); end
  endtask

  task automatic test_branch();
    instr_t bl;
    do_reset();
    apply(beq(4, 5), 0, 0);
    tick();
    apply(rtype(1, 2, 3, 2'b10), 1, 0);
    total++; if (IFIDFlush !== 1'b1 || PCWrite !== 1'b1) begin bad++; $display("FAIL br_flush: got %b %b want 1 1", IFIDFlush, PCWrite); end
    tick();
    apply(nop(), 0, 0);
    total++; if (ExBranch !== 1'b0 || FlushCount !== 8'd1) begin bad++; $display("FAIL br_after: got %b %0d want 0 1", ExBranch, FlushCount); end
    bl = beq(4, 6); bl.mem_read = 1;
    apply(bl, 0, 0);
    tick();
    apply(rtype(6, 1, 2, 2'b10), 1, 0);
    total++; if (IFIDFlush !== 1'b1 || PCWrite !== 1'b1) begin bad++; $display("FAIL br_over_stall: got %b %b want 1 1", IFIDFlush, PCWrite); end
    tick();
    total++; if (StallCount !== 8'd0 || FlushCount !== 8'd2 || ExBranch !== 1'b0) begin bad++; $display("FAIL br_counts: got %0d %0d %b want 0 2 0", StallCount, FlushCount, ExBranch); end
  endtask

  task automatic test_jal();
    do_reset();
    apply(jmp(1), 0, 0);
    total++; if (IFIDFlush !== 1'b1 || PCWrite !== 1'b1) begin bad++; $display("FAIL jal_flush: got %b %b want 1 1", IFIDFlush, PCWrite); end
    tick();
    apply(nop(), 0, 0);
    total++; if (ExWriteReg !== 5'd31 || FlushCount !== 8'd1) begin bad++; $display("FAIL jal_ex: got %0d %0d want 31 1", ExWriteReg, FlushCount); end
    tick(); tick();
    total++; if (WbJAL !== 1'b1 || WbRegWrite !== 1'b1 || WbWriteReg !== 5'd31) begin bad++; $display("FAIL jal_wb: got %b %b %0d want 1 1 31", WbJAL, WbRegWrite, WbWriteReg); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    apply(rtype(1, 2, 5, 2'b00), 0, 0); tick();
    apply(rtype(5, 7, 6, 2'b01), 0, 0); tick();
    apply(rtype(8, 5, 9, 2'b00), 0, 0);
    total++; if (ForwardA !== 2'b10 || ForwardB !== 2'b00) begin bad++; $display("FAIL b2b_mem: got %b %b want 10 00", ForwardA, ForwardB); end
    tick();
    apply(rtype(1, 2, 0, 2'b00), 0, 0);
    total++; if (ForwardB !== 2'b01 || ForwardA !== 2'b00) begin bad++; $display("FAIL b2b_wb_b: got %b %b want 00 01", ForwardA, ForwardB); end
    tick();
    apply(rtype(0, 0, 4, 2'b00), 0, 0); tick();
    total++; if (ForwardA !== 2'b00 || ForwardB !== 2'b00) begin bad++; $display("FAIL b2b_r0: got %b %b want 00 00", ForwardA, ForwardB); end
    apply(rtype(1, 2, 5, 2'b00), 0, 0); tick();
    apply(rtype(1, 2, 5, 2'b00), 0, 0); tick();
    apply(rtype(5, 5, 3, 2'b00), 0, 0); tick();
    total++; if (ForwardA !== 2'b10 || ForwardB !== 2'b10) begin bad++; $display("FAIL b2b_prio: got %b %b want 10 10", ForwardA, ForwardB); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    apply(jmp(0), 0, 0); tick();
    apply(lw(1, 9), 0, 0); tick();
    apply(sw(2, 3), 0, 0); tick();
    apply(nop(), 0, 0);
    total++; if (MemMemRead !== 1'b1 || FlushCount !== 8'd1) begin bad++; $display("FAIL mid_setup: got %b %0d want 1 1", MemMemRead, FlushCount); end
    apply(nop(), 0, 1); tick();
    apply(nop(), 0, 0);
    total++; if (MemMemWrite !== 1'b0 || MemMemRead !== 1'b0 || PCWrite !== 1'b1) begin bad++; $display("FAIL mid_clear: got %b %b %b want 0 0 1", MemMemWrite, MemMemRead, PCWrite); end
    total++; if (StallCount !== '0 || FlushCount !== '0 || WbRegWrite !== 1'b0) begin bad++; $display("FAIL mid_counts: got %0d %0d %b want 0 0 0", StallCount, FlushCount, WbRegWrite); end
    total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL mid_model: got %h want %h", dut_vec, exp_vec()); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      apply(lw(9, 9), 0, 0);
      tick();
    end
    total++; if (StallCount !== CNT_W'(CNT_MAX)) begin bad++; $display("FAIL sat_stall: got %0d want %0d", StallCount, CNT_MAX); end
    for (int i = 0; i < 300; i++) begin
      apply(jmp(0), 0, 0);
      tick();
    end
    total++; if (FlushCount !== CNT_W'(CNT_MAX) || StallCount !== CNT_W'(CNT_MAX)) begin bad++; $display("FAIL sat_flush: got %0d %0d want %0d %0d", FlushCount, StallCount, CNT_MAX, CNT_MAX); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      apply(rand_instr(), 1'($urandom), ($urandom_range(0, 149) == 0));
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++;
        $display("FAIL rand_cycle%0d: got %h want %h", i, dut_vec, exp_vec());
      end
      tick();
    end
  endtask

  initial begin
    apply(nop(), 0, 1);
    @(negedge CLK);
    test_reset();
    test_rtype();
    test_load_use();
    test_branch();
    test_jal();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
